// File: rtl/wb_inp_bank.sv
// wb_inp_bank: 32-word input bank filled by a load stream, read and released over Wishbone.
// Define WB_INP_BANK_IRQ_EN to enable the registered full interrupt and CTRL bit1 (irq_en).
module wb_inp_bank #(
    parameter int          WB_DWIDTH = 32,
    parameter int          WB_SWIDTH = 4,
    parameter logic [31:0] BASE_ADR  = 32'hFF700000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ld_valid,
    input  logic [31:0]          i_ld_data,
    output logic                 o_ld_ready,
    input  logic [31:0]          i_wb_adr,
    input  logic [WB_SWIDTH-1:0] i_wb_sel,
    input  logic                 i_wb_we,
    input  logic [WB_DWIDTH-1:0] i_wb_dat,
    output logic [WB_DWIDTH-1:0] o_wb_dat,
    input  logic                 i_wb_cyc,
    input  logic                 i_wb_stb,
    output logic                 o_wb_ack,
    output logic                 o_wb_err,
    output logic                 o_full,
    output logic                 o_irq
);
    typedef enum logic {LOAD, FULL} state_t;

    state_t               state_q, state_d;
    logic [5:0]           count_q, count_d;
    logic                 irq_en_q, irq_en_d, irq_q, irq_d;
    logic [31:0]          mem_q [32];
    logic                 p1_q, p2_q, e1_q, e2_q;
    logic [31:0]          d1_q;
    logic [WB_DWIDTH-1:0] dat_q;

    logic        hit, busy, rd_acc, wr_acc, is_word, is_stat, is_ctrl, ctrl_wr, rel, ld_hs;
    logic [9:0]  off;
    logic [4:0]  n;
    logic [31:0] status, rd_val;
    logic        unused_ok;

    assign off     = i_wb_adr[9:0];
    assign n       = off[8:4];
    assign hit     = i_wb_adr[31:10] == BASE_ADR[31:10] && i_wb_stb && i_wb_cyc;
    assign busy    = p1_q || p2_q;
    assign rd_acc  = hit && !i_wb_we && !busy;
    assign wr_acc  = hit && i_wb_we && !busy;
    assign is_word = !off[9] && off[3:0] == 4'h0;
    assign is_stat = off == 10'h200;
    assign is_ctrl = off == 10'h204;
    assign ctrl_wr = wr_acc && is_ctrl;
    assign rel     = ctrl_wr && i_wb_dat[0];
    assign ld_hs   = i_ld_valid && state_q == LOAD;
    assign status  = {24'h0, irq_en_q, count_q, state_q == FULL};
    // Words at or beyond the fill level read as zero even if stale data remains.
    assign rd_val  = is_stat ? status : ({1'b0, n} < count_q) ? mem_q[n] : 32'h0;

    assign o_ld_ready = state_q == LOAD;
    assign o_full     = state_q == FULL;
    assign o_wb_dat   = dat_q;
    assign o_wb_ack   = (p2_q && !e2_q && i_wb_stb) || ctrl_wr;
    assign o_wb_err   = (p2_q && e2_q && i_wb_stb) || (wr_acc && !is_ctrl);
    assign o_irq      = irq_q;
    assign unused_ok  = ^{i_wb_sel, i_wb_dat};

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        irq_en_d = irq_en_q;
        if (ld_hs) begin
            count_d = count_q + 6'd1;
            state_d = count_q == 6'd31 ? FULL : LOAD;
        end
        // Release wins over a coinciding load handshake.
        if (rel) begin
            count_d = 6'd0;
            state_d = LOAD;
        end
`ifdef WB_INP_BANK_IRQ_EN
        if (ctrl_wr) irq_en_d = i_wb_dat[1];
        irq_d = irq_en_q && state_q == FULL;
`else
        irq_en_d = 1'b0;
        irq_d    = 1'b0;
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= LOAD;
            count_q  <= 6'd0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
            p1_q     <= 1'b0;
            p2_q     <= 1'b0;
            e1_q     <= 1'b0;
            e2_q     <= 1'b0;
            d1_q     <= 32'h0;
            dat_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
            p1_q     <= rd_acc;
            e1_q     <= !(is_word || is_stat);
            d1_q     <= rd_val;
            p2_q     <= p1_q;
            e2_q     <= e1_q;
            if (p1_q && !e1_q) dat_q <= d1_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (ld_hs && !rel) mem_q[count_q[4:0]] <= i_ld_data;
    end
endmodule

// File: tb/tb_wb_inp_bank.sv
// tb_wb_inp_bank: randomized self-checking bench for wb_inp_bank against a fill-level/array model.
module tb_wb_inp_bank;
    localparam logic [31:0] BASE = 32'hFF700000;
    localparam logic [31:0] CTRL = 32'hFF700204;
    localparam logic [31:0] STAT = 32'hFF700200;
`ifdef WB_INP_BANK_IRQ_EN
    localparam bit HAS_IRQ = 1'b1;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, ld_valid = 1'b0, we = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic ld_ready, ack, err, full, irq;
    logic [31:0] ld_data = '0, adr = '0, wdat = '0, rdat;
    logic [3:0]  sel = 4'hF;
    int vectors = 0, errors = 0;
    logic [31:0] m_mem [32];
    int m_count = 0;
    bit m_irq_en = 1'b0;

    wb_inp_bank dut (
        .i_clk(clk), .i_rst(rst), .i_ld_valid(ld_valid), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
        .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_we(we), .i_wb_dat(wdat), .o_wb_dat(rdat),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .o_wb_ack(ack), .o_wb_err(err), .o_full(full), .o_irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] m_status();
        return {24'h0, m_irq_en && HAS_IRQ, 6'(m_count), m_count == 32};
    endfunction

    function automatic logic [31:0] m_word(int n);
        return n < m_count ? m_mem[n] : 32'h0;
    endfunction

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output logic ok, output logic er, output int lat);
        adr = a; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        d = 'x; ok = 1'b0; er = 1'b0; lat = -1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (ack || err) begin
                d = rdat; ok = ack; er = err; lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] v, output logic ok, output logic er);
        adr = a; wdat = v; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        #1; ok = ack; er = err;
        @(posedge clk); #1;
        we = 1'b0; cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic ctrl(input logic [31:0] v, output logic ok);
        logic er;
        wb_write(CTRL, v, ok, er);
        if (v[0]) m_count = 0;
        m_irq_en = v[1];
    endtask

    task automatic ld_push(input logic [31:0] v, output logic rdy);
        ld_valid = 1'b1; ld_data = v;
        #1; rdy = ld_ready;
        if (m_count < 32) begin
            m_mem[m_count] = v;
            m_count++;
        end
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", ld_ready); end
        vectors++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", full); end
        vectors++; if ({ack, err} !== 2'b00) begin errors++; $display("FAIL rst_ack_err: got %b want 00", {ack, err}); end
        vectors++; if (rdat !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h want 0", rdat); end
        vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq); end
        rst = 1'b0; m_count = 0; m_irq_en = 1'b0;
        idle();
        vectors++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", ld_ready); end
    endtask

    task automatic test_fill();
        logic [31:0] d; logic ok, er; int lat;
        for (int i = 0; i <= 32; i++) begin
            ld_valid = 1'b1; ld_data = 32'hA0000000 + i;
            #1;
            vectors++; if (ld_ready !== (m_count < 32)) begin errors++; $display("FAIL fill_ready i=%0d: got %b want %b", i, ld_ready, m_count < 32); end
            if (m_count < 32) begin
                m_mem[m_count] = ld_data;
                m_count++;
            end
            idle();
        end
        ld_valid = 1'b0;
        vectors++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", full); end
        wb_read(STAT, d, ok, er, lat);
        vectors++; if (d !== 32'h41 || d !== m_status() || !ok || lat != 2) begin errors++; $display("FAIL fill_status: got %h ack=%b lat=%0d want 41 ack=1 lat=2", d, ok, lat); end
    endtask

    task automatic test_read_words();
        logic [31:0] d; logic ok, er; int lat, n;
        wb_read(BASE + 32'h150, d, ok, er, lat);
        vectors++; if (d !== 32'hA0000015 || !ok || er || lat != 2) begin errors++; $display("FAIL rd_150: got %h ack=%b err=%b lat=%0d want a0000015 ack=1 err=0 lat=2", d, ok, er, lat); end
        repeat (6) begin
            n = $urandom_range(0, 31);
            wb_read(BASE + 32'(n * 16), d, ok, er, lat);
            vectors++; if (d !== m_word(n) || !ok || lat != 2) begin errors++; $display("FAIL rd_word n=%0d: got %h lat=%0d want %h lat=2", n, d, lat, m_word(n)); end
        end
        repeat (3) idle();
        vectors++; if (rdat !== d) begin errors++; $display("FAIL rd_hold: got %h want %h", rdat, d); end
    endtask

    task automatic test_full_hold();
        logic [31:0] d; logic ok, er, rdy; int lat;
        repeat (2) begin
            ld_push($urandom, rdy);
            vectors++; if (rdy !== 1'b0) begin errors++; $display("FAIL full_hold_ready: got %b want 0", rdy); end
        end
        wb_read(STAT, d, ok, er, lat);
        vectors++; if (d !== m_status() || full !== 1'b1) begin errors++; $display("FAIL full_hold_status: got %h full=%b want %h full=1", d, full, m_status()); end
    endtask

    task automatic test_release();
        logic [31:0] d; logic ok, er, rdy; int lat;
        ld_valid = 1'b1; ld_data = $urandom;
        ctrl(32'h1, ok);
        vectors++; if (!ok || ld_ready !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rel_full: got ack=%b ready=%b full=%b want 1 1 0", ok, ld_ready, full); end
        ld_valid = 1'b0;
        repeat (3) ld_push($urandom, rdy);
        ld_valid = 1'b1; ld_data = 32'hDEADBEEF;
        ctrl(32'h1, ok);
        ld_valid = 1'b0;
        wb_read(STAT, d, ok, er, lat);
        vectors++; if (d !== m_status() || d !== 32'h0) begin errors++; $display("FAIL rel_collide_status: got %h want 0", d); end
        wb_read(BASE, d, ok, er, lat);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL rel_collide_word0: got %h want 0", d); end
    endtask

    task automatic test_partial();
        logic [31:0] d; logic ok, er, rdy; int lat;
        repeat (5) ld_push($urandom, rdy);
        wb_read(BASE + 32'h70, d, ok, er, lat);
        vectors++; if (d !== 32'h0 || !ok) begin errors++; $display("FAIL part_word7: got %h ack=%b want 0 ack=1", d, ok); end
        wb_read(STAT, d, ok, er, lat);
        vectors++; if (d !== 32'h0A) begin errors++; $display("FAIL part_status: got %h want 0a", d); end
        wb_read(BASE + 32'h30, d, ok, er, lat);
        vectors++; if (d !== m_word(3)) begin errors++; $display("FAIL part_word3: got %h want %h", d, m_word(3)); end
    endtask

    task automatic test_concurrent();
        logic [31:0] exp_s, d; logic ok, er; int lat;
        exp_s = m_status();
        ld_valid = 1'b1; ld_data = $urandom;
        adr = STAT; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        idle();
        ld_valid = 1'b0;
        m_mem[m_count] = ld_data; m_count++;
        @(posedge clk); #2;
        vectors++; if (ack !== 1'b1 || rdat !== exp_s) begin errors++; $display("FAIL conc_status: got %h ack=%b want %h ack=1", rdat, ack, exp_s); end
        cyc = 1'b0; stb = 1'b0;
        idle();
        wb_read(BASE + 32'(16 * (m_count - 1)), d, ok, er, lat);
        vectors++; if (d !== m_word(m_count - 1)) begin errors++; $display("FAIL conc_word: got %h want %h", d, m_word(m_count - 1)); end
    endtask

    task automatic test_errors();
        logic [9:0] eoff [6] = '{10'h208, 10'h010, 10'h204, 10'h154, 10'h200, 10'h3FC};
        bit ewe [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] d; logic ok, er; int lat;
        for (int i = 0; i < 6; i++) begin
            if (ewe[i]) begin
                wb_write(BASE + 32'(eoff[i]), 32'h3, ok, er);
                lat = 0;
            end else begin
                wb_read(BASE + 32'(eoff[i]), d, ok, er, lat);
            end
            vectors++; if ({ok, er} !== 2'b01 || lat != (ewe[i] ? 0 : 2)) begin errors++; $display("FAIL err_%h: got ack=%b err=%b lat=%0d want ack=0 err=1", eoff[i], ok, er, lat); end
        end
        wb_read(STAT, d, ok, er, lat);
        vectors++; if (d !== m_status()) begin errors++; $display("FAIL err_state: got %h want %h", d, m_status()); end
    endtask

    task automatic test_nonhit();
        logic [31:0] d; logic ok, er; int lat;
        wb_read(32'hFF700400, d, ok, er, lat);
        vectors++; if (ok || er || lat != -1) begin errors++; $display("FAIL nonhit_rd: got ack=%b err=%b lat=%0d want no response", ok, er, lat); end
        wb_write(32'hFE700204, 32'h1, ok, er);
        vectors++; if (ok || er) begin errors++; $display("FAIL nonhit_wr: got ack=%b err=%b want 0 0", ok, er); end
        wb_read(STAT, d, ok, er, lat);
        vectors++; if (d !== m_status()) begin errors++; $display("FAIL nonhit_state: got %h want %h", d, m_status()); end
    endtask

    task automatic test_irq();
        logic [31:0] d; logic ok, er, rdy; int lat;
        ctrl(32'h1, ok);
        ctrl(32'h2, ok);
        while (m_count < 32) ld_push($urandom, rdy);
        vectors++; if (full !== 1'b1 || irq !== 1'b0) begin errors++; $display("FAIL irq_fill_edge: got full=%b irq=%b want 1 0", full, irq); end
        idle();
        vectors++; if (irq !== HAS_IRQ) begin errors++; $display("FAIL irq_rise: got %b want %b", irq, HAS_IRQ); end
        wb_read(STAT, d, ok, er, lat);
        vectors++; if (d !== m_status()) begin errors++; $display("FAIL irq_status: got %h want %h", d, m_status()); end
        ctrl(32'h1, ok);
        vectors++; if (irq !== HAS_IRQ) begin errors++; $display("FAIL irq_rel_lag: got %b want %b", irq, HAS_IRQ); end
        idle();
        vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_rel_fall: got %b want 0", irq); end
        ctrl(32'h2, ok);
        while (m_count < 32) ld_push($urandom, rdy);
        idle();
        ctrl(32'h0, ok);
        idle();
        vectors++; if (irq !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL irq_disable: got irq=%b full=%b want 0 1", irq, full); end
    endtask

    task automatic test_random();
        logic [31:0] d; logic ok, er, rdy, exp_r; int lat, n, op;
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                exp_r = m_count < 32;
                ld_push($urandom, rdy);
                vectors++; if (rdy !== exp_r) begin errors++; $display("FAIL rnd_ready it=%0d: got %b want %b", it, rdy, exp_r); end
            end else if (op <= 6) begin
                n = $urandom_range(0, 31);
                wb_read(BASE + 32'(n * 16), d, ok, er, lat);
                vectors++; if (d !== m_word(n) || !ok || lat != 2) begin errors++; $display("FAIL rnd_word it=%0d n=%0d: got %h want %h", it, n, d, m_word(n)); end
            end else if (op == 7) begin
                wb_read(STAT, d, ok, er, lat);
                vectors++; if (d !== m_status()) begin errors++; $display("FAIL rnd_status it=%0d: got %h want %h", it, d, m_status()); end
            end else if (op == 8) begin
                ctrl({30'h0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0}, ok);
                vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL rnd_ctrl it=%0d: got ack=%b want 1", it, ok); end
            end else begin
                wb_read(BASE + 32'($urandom_range(32'h208, 32'h3FF)), d, ok, er, lat);
                vectors++; if ({ok, er} !== 2'b01 || lat != 2) begin errors++; $display("FAIL rnd_err it=%0d: got ack=%b err=%b lat=%0d want 0 1 2", it, ok, er, lat); end
            end
            vectors++; if (full !== (m_count == 32)) begin errors++; $display("FAIL rnd_full it=%0d: got %b want %b", it, full, m_count == 32); end
        end
    endtask

    task automatic test_reset_midread();
        logic [31:0] d; logic ok, er; int lat;
        adr = BASE; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        idle();
        rst = 1'b1;
        #1;
        vectors++; if (rdat !== 32'h0 || ack !== 1'b0) begin errors++; $display("FAIL midrst_async: got dat=%h ack=%b want 0 0", rdat, ack); end
        idle();
        rst = 1'b0; m_count = 0; m_irq_en = 1'b0;
        #1;
        vectors++; if (ack !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL midrst_noack: got ack=%b err=%b want 0 0", ack, err); end
        cyc = 1'b0; stb = 1'b0;
        idle();
        vectors++; if (ld_ready !== 1'b1 || full !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL midrst_state: got ready=%b full=%b irq=%b want 1 0 0", ld_ready, full, irq); end
        wb_read(STAT, d, ok, er, lat);
        vectors++; if (d !== 32'h0 || !ok) begin errors++; $display("FAIL midrst_status: got %h ack=%b want 0 ack=1", d, ok); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_read_words();
        test_full_hold();
        test_release();
        test_partial();
        test_concurrent();
        test_errors();
        test_nonhit();
        test_irq();
        test_random();
        test_reset_midread();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/wb_inp_bank.md
WB_INP_BANK -- requirements
Module: wb_inp_bank

Interface
REQ-001 SHALL have parameter WB_DWIDTH, default 32, Wishbone data width; only 32 is supported.
REQ-002 SHALL have parameter WB_SWIDTH, default 4, Wishbone byte-select width.
REQ-003 SHALL have parameter BASE_ADR, default 32'hFF700000, 1 KB-aligned window base.
REQ-004 SHALL have ports:
- i_clk  in  1  single clock; all state on rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_ld_valid  in  1  load word offered.
- i_ld_data  in  32  load word.
- o_ld_ready  out  1  bank accepts load word.
- i_wb_adr  in  32  Wishbone address.
- i_wb_sel  in  WB_SWIDTH  byte selects; ignored.
- i_wb_we  in  1  write enable.
- i_wb_dat  in  WB_DWIDTH  write data.
- o_wb_dat  out  WB_DWIDTH  read data.
- i_wb_cyc  in  1  cycle.
- i_wb_stb  in  1  strobe.
- o_wb_ack  out  1  acknowledge.
- o_wb_err  out  1  error.
- o_full  out  1  32 words held.
- o_irq  out  1  full interrupt; see Configuration.

Function
REQ-005 SHALL hold 32 words, mem[0..31], plus a 6-bit count (0..32) and state LOAD or FULL.
REQ-006 SHALL drive o_ld_ready = (state==LOAD).
REQ-007 SHALL write i_ld_data to mem[count] and increment count on i_ld_valid && o_ld_ready.
REQ-008 SHALL transition LOAD->FULL on the handshake that makes count 32; o_full = (state==FULL).
REQ-009 SHALL decode a hit when i_wb_adr[31:10]==BASE_ADR[31:10] and i_wb_stb && i_wb_cyc; non-hits produce no ack and no err.
REQ-010 SHALL define the map by offset i_wb_adr[9:0]:
- 0x000-0x1F0, step 0x10: word n = adr[8:4]; read-only.
- 0x200: STATUS, read-only; bit0 full, bits[6:1] count, bit7 irq_en.
- 0x204: CTRL, write; bit0 release, bit1 irq_en.
REQ-011 SHALL return mem[n] for a word read when n < count, else 32'h0.
REQ-012 SHALL apply read latency 2: a read accepted in cycle T (hit, !we, !busy) sets busy for T+1 and T+2, registers data into o_wb_dat, and asserts o_wb_ack for one cycle in T+2 if i_wb_stb is still high.
REQ-013 SHALL ack a write combinationally in the cycle it is presented (hit, we, !busy).
REQ-014 SHALL hold o_wb_dat at the last read value between reads.
REQ-015 SHALL respond to an unmapped offset (word area with adr[3:0]!=0, 0x208-0x3FF, write to word area or STATUS, read of CTRL) by pulsing o_wb_err with the normal ack timing, with o_wb_ack low and no state change.
REQ-016 SHALL, on a CTRL write with bit0=1, clear count to 0 and enter LOAD next cycle; mem contents are not cleared.
REQ-017 SHALL latch irq_en from CTRL bit1 on every CTRL write.
REQ-018 SHALL give release priority when it coincides with a load handshake: the word is discarded and count becomes 0.
REQ-019 SHALL leave state and count unchanged by further i_ld_valid while FULL.
REQ-020 SHALL let a load handshake and a Wishbone read proceed in the same cycle; the read returns the pre-edge count view.

Reset
REQ-021 SHALL, on i_rst, asynchronously force: state LOAD, count 0, irq_en 0, busy 0, o_wb_dat 0, o_wb_ack 0, o_wb_err 0, o_irq 0; o_ld_ready is 1 after reset.
REQ-022 SHALL abort a pending read on reset mid-read with no ack; mem contents are undefined after reset.

Configuration
REQ-023 SHALL, with WB_INP_BANK_IRQ_EN defined, register o_irq = irq_en && state==FULL, asserting one cycle after the fill edge and clearing one cycle after release or after irq_en is written to 0.
REQ-024 SHALL, without WB_INP_BANK_IRQ_EN, tie o_irq to 0, reading STATUS bit7 as 0 and ignoring CTRL bit1.

Verification
REQ-025 Reset then load 32 words 0xA0000000+n back-to-back -> o_ld_ready drops after word 31; o_full=1; STATUS reads 0x41.
REQ-026 Read 0xFF700150 after a full load -> ack exactly 2 cycles after stb with o_wb_dat=0xA0000015.
REQ-027 Load 5 words then read word 7 -> returns 0; STATUS reads 0x0A.
REQ-028 Write CTRL=0x1 while FULL, simultaneous with i_ld_valid -> count 0, o_ld_ready=1 next cycle, word discarded.
REQ-029 Read 0xFF700208; write to 0xFF700010 -> o_wb_err pulses, no ack, state unchanged.
REQ-030 With WB_INP_BANK_IRQ_EN: CTRL=0x2 then fill -> o_irq rises one cycle after full; CTRL=0x1 -> o_irq falls; without macro o_irq stays 0.
